// File: rtl/ddr_axi_pkg.sv
// Shared AXI constants, writer FSM states and the burst-length splitter.
package ddr_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam int         BOUNDARY_4K     = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } wr_state_e;

  // Beats in the next burst: the smallest of what is left, the burst cap and room to the 4 KB edge.
  function automatic logic [8:0] burst_len(input logic [11:0] addr_lo,
                                           input logic [15:0] remaining,
                                           input int          max_burst,
                                           input int          bytes_per_beat);
    int lim;
    int rem;
    int page;
    page = {20'd0, addr_lo};
    rem  = {16'd0, remaining};
    lim  = (BOUNDARY_4K - page) / bytes_per_beat;
    if (max_burst < lim) lim = max_burst;
    if (rem < lim) lim = rem;
    return lim[8:0];
  endfunction

endpackage

// File: rtl/axi_outst_tracker.sv
// Counts bursts whose address was accepted but whose write response is still pending.
module axi_outst_tracker #(
  parameter int MAX_OUTST = 4
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic       full
);

  logic [3:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (inc && !dec) begin
      count_reg <= count_reg + 4'd1;
    end else if (dec && !inc && count_reg != 4'd0) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign count = count_reg;
  assign full  = (count_reg == 4'(MAX_OUTST));

endmodule

// File: rtl/ddr3_axi_burst_writer.sv
// AXI4 INCR write-burst master: splits a (address, beats) command at 4 KB and MAX_BURST.
// Define DDR_WR_BURST_STATS_EN to add saturating burst/stall counters.
module ddr3_axi_burst_writer
  import ddr_axi_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 256,
  parameter int MAX_OUTST = 4
) (
  input  logic                USER_CLK,
  input  logic                USER_RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [15:0]         cmd_beats,
  output logic                done_valid,
  output logic                done_err,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY
`ifdef DDR_WR_BURST_STATS_EN
  ,
  output logic [31:0]         stat_bursts,
  output logic [31:0]         stat_stall
`endif
);

  localparam int BYTES    = DATA_W / 8;
  localparam int SIZE_LOG = $clog2(BYTES);

  wr_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       remaining_reg;
  logic [7:0]        beat_reg;
  logic              err_reg;
  logic [8:0]        blen;
  logic [3:0]        outst;
  logic              outst_full;
  logic              accept, aw_hs, w_hs, b_hs;

  // addr_reg and remaining_reg only move at WLAST, so blen is stable through ADDR and DATA.
  assign blen = burst_len(addr_reg[11:0], remaining_reg, MAX_BURST, BYTES);

  assign M_AXI_AWADDR = addr_reg;
  assign M_AXI_AWLEN  = 8'(blen - 9'd1);
  assign M_AXI_WDATA  = s_data;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_BREADY = !USER_RST;
  assign done_err     = done_valid && err_reg;

  assign accept = cmd_valid && cmd_ready;
  assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs   = M_AXI_BVALID && M_AXI_BREADY;

  axi_outst_tracker #(
    .MAX_OUTST (MAX_OUTST)
  ) u_outst (
    .clk   (USER_CLK),
    .srst  (USER_RST),
    .inc   (aw_hs),
    .dec   (b_hs),
    .count (outst),
    .full  (outst_full)
  );

  always_comb begin
    state_next    = state_reg;
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    s_ready       = 1'b0;
    done_valid    = 1'b0;
    // Handshake outputs are held low while reset is asserted.
    if (!USER_RST) begin
      unique case (state_reg)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) state_next = (cmd_beats == 16'd0) ? ST_DRAIN : ST_ADDR;
        end
        ST_ADDR: begin
          M_AXI_AWVALID = !outst_full;
          if (!outst_full && M_AXI_AWREADY) state_next = ST_DATA;
        end
        ST_DATA: begin
          M_AXI_WVALID = s_valid;
          s_ready      = M_AXI_WREADY;
          M_AXI_WLAST  = ({1'b0, beat_reg} == (blen - 9'd1));
          if (s_valid && M_AXI_WREADY && M_AXI_WLAST)
            state_next = (remaining_reg == 16'(blen)) ? ST_DRAIN : ST_ADDR;
        end
        ST_DRAIN: begin
          if (outst == 4'd0) begin
            done_valid = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (USER_RST) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      beat_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg      <= cmd_addr;
        remaining_reg <= cmd_beats;
        beat_reg      <= '0;
      end else if (w_hs) begin
        if (M_AXI_WLAST) begin
          beat_reg      <= '0;
          addr_reg      <= addr_reg + (ADDR_W'(blen) << SIZE_LOG);
          remaining_reg <= remaining_reg - 16'(blen);
        end else begin
          beat_reg <= beat_reg + 8'd1;
        end
      end
      if (accept) err_reg <= 1'b0;
      else if (M_AXI_BVALID && M_AXI_BRESP != AXI_RESP_OKAY) err_reg <= 1'b1;
    end
  end

`ifdef DDR_WR_BURST_STATS_EN
  logic [31:0] stat_bursts_reg;
  logic [31:0] stat_stall_reg;

  always_ff @(posedge USER_CLK) begin
    if (USER_RST) begin
      stat_bursts_reg <= '0;
      stat_stall_reg  <= '0;
    end else begin
      if (aw_hs && stat_bursts_reg != '1) stat_bursts_reg <= stat_bursts_reg + 32'd1;
      if (M_AXI_WVALID && !M_AXI_WREADY && stat_stall_reg != '1)
        stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_bursts = stat_bursts_reg;
  assign stat_stall  = stat_stall_reg;
`endif

endmodule
